// File: rtl/grid_vga_scanner_pkg.sv
// ============================================================================
// Module      : grid_vga_scanner_pkg
// Description : Block codes, colour map and VGA timing defaults shared by the
//               grid scanner and its timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package grid_vga_scanner_pkg;

  localparam int GRID_WIDTH     = 64;
  localparam int GRID_HEIGHT    = 48;
  localparam int BITS_PER_BLOCK = 2;
  localparam int ROW_W          = $clog2(GRID_HEIGHT);
  localparam int COL_W          = $clog2(GRID_WIDTH);

  typedef enum logic [BITS_PER_BLOCK-1:0] {
    BLOCK_EMPTY = 2'd0,
    BLOCK_WALL  = 2'd1,
    BLOCK_SNAKE = 2'd2,
    BLOCK_FOOD  = 2'd3
  } block_t;

  localparam logic [7:0] COLOUR_EMPTY = 8'h00;
  localparam logic [7:0] COLOUR_WALL  = 8'hFF;
  localparam logic [7:0] COLOUR_SNAKE = 8'h1C;
  localparam logic [7:0] COLOUR_FOOD  = 8'hE0;
  localparam logic [7:0] COLOUR_BLANK = 8'h00;

  // 640x480@60 defaults; counters are wide enough for any total up to 1023
  localparam int VGA_H_VIS = 640;
  localparam int VGA_H_FP  = 16;
  localparam int VGA_H_SW  = 96;
  localparam int VGA_H_BP  = 48;
  localparam int VGA_V_VIS = 480;
  localparam int VGA_V_FP  = 10;
  localparam int VGA_V_SW  = 2;
  localparam int VGA_V_BP  = 33;
  localparam int CNT_W     = 10;

  function automatic logic [7:0] blockColour(input logic [BITS_PER_BLOCK-1:0] code);
    logic [7:0] colour;
    colour = COLOUR_EMPTY;
    case (block_t'(code))
      BLOCK_WALL:  colour = COLOUR_WALL;
      BLOCK_SNAKE: colour = COLOUR_SNAKE;
      BLOCK_FOOD:  colour = COLOUR_FOOD;
      default:     colour = COLOUR_EMPTY;
    endcase
    return colour;
  endfunction

endpackage

`default_nettype wire

// File: rtl/grid_vga_scanner_vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Pixel-clock divider, raster counters and sync/visible decode.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_timing_gen
  import grid_vga_scanner_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SW    = VGA_H_SW,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SW    = VGA_V_SW,
  parameter int V_BP    = VGA_V_BP
) (
  input  logic             MasterClock,
  input  logic             Reset,
  output logic             PixelTick,
  output logic [CNT_W-1:0] HCount,
  output logic [CNT_W-1:0] VCount,
  output logic             HLast,
  output logic             VLast,
  output logic             Visible,
  output logic             HSyncN,
  output logic             VSyncN
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_hCount;
  logic [CNT_W-1:0] r_vCount;
  logic             w_tick;
  logic             w_hLast;
  logic             w_vLast;

  assign w_tick  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_hLast = (r_hCount == CNT_W'(H_TOTAL - 1));
  assign w_vLast = (r_vCount == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      r_div    <= '0;
      r_hCount <= '0;
      r_vCount <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_hCount <= w_hLast ? '0 : r_hCount + 1'b1;
        if (w_hLast) begin
          r_vCount <= w_vLast ? '0 : r_vCount + 1'b1;
        end
      end
    end
  end

  assign PixelTick = w_tick;
  assign HCount    = r_hCount;
  assign VCount    = r_vCount;
  assign HLast     = w_hLast;
  assign VLast     = w_vLast;
  assign Visible   = (r_hCount < CNT_W'(H_VIS)) && (r_vCount < CNT_W'(V_VIS));
  assign HSyncN    = !((r_hCount >= CNT_W'(H_VIS + H_FP)) && (r_hCount < CNT_W'(H_VIS + H_FP + H_SW)));
  assign VSyncN    = !((r_vCount >= CNT_W'(V_VIS + V_FP)) && (r_vCount < CNT_W'(V_VIS + V_FP + V_SW)));

endmodule

`default_nettype wire

// File: rtl/grid_vga_scanner.sv
// ============================================================================
// Module      : grid_vga_scanner
// Description : Scans the game-grid RAM in raster order and drives VGA colour,
//               syncs and a one-cycle FrameDone pulse at vblank start.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module grid_vga_scanner
  import grid_vga_scanner_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int BLOCK_PX = 10,
  parameter int H_VIS    = VGA_H_VIS,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SW     = VGA_H_SW,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_VIS    = VGA_V_VIS,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SW     = VGA_V_SW,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic                      MasterClock,
  input  logic                      Reset,
  output logic [ROW_W-1:0]          GridRow,
  output logic [COL_W-1:0]          GridCol,
  output logic                      GridRead,
  input  logic [BITS_PER_BLOCK-1:0] GridData,
  output logic [7:0]                VGArgb,
  output logic                      VGAHSync,
  output logic                      VGAVSync,
  output logic                      FrameDone
);

  localparam int SUB_W = (BLOCK_PX > 1) ? $clog2(BLOCK_PX) : 1;

  logic             w_tick;
  logic [CNT_W-1:0] w_hCount;
  logic [CNT_W-1:0] w_vCount;
  logic             w_hLast;
  logic             w_vLast;
  logic             w_visible;
  logic             w_hSyncN;
  logic             w_vSyncN;
  logic [CNT_W-1:0] w_nextH;
  logic [CNT_W-1:0] w_nextV;
  logic             w_nextVisible;
  logic             w_hSubLast;
  logic             w_vSubLast;

  logic [SUB_W-1:0] r_hSub;
  logic [SUB_W-1:0] r_vSub;
  logic [COL_W-1:0] r_gridCol;
  logic [ROW_W-1:0] r_gridRow;
  logic             r_gridRead;
  logic [7:0]       r_rgb;
  logic             r_hSync;
  logic             r_vSync;
  logic             r_frameDone;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SW    (H_SW),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SW    (V_SW),
    .V_BP    (V_BP)
  ) u_timing (
    .MasterClock (MasterClock),
    .Reset       (Reset),
    .PixelTick   (w_tick),
    .HCount      (w_hCount),
    .VCount      (w_vCount),
    .HLast       (w_hLast),
    .VLast       (w_vLast),
    .Visible     (w_visible),
    .HSyncN      (w_hSyncN),
    .VSyncN      (w_vSyncN)
  );

  // GridRead must describe the counter values being loaded on this tick
  assign w_nextH       = w_hLast ? '0 : w_hCount + 1'b1;
  assign w_nextV       = w_hLast ? (w_vLast ? '0 : w_vCount + 1'b1) : w_vCount;
  assign w_nextVisible = (w_nextH < CNT_W'(H_VIS)) && (w_nextV < CNT_W'(V_VIS));
  assign w_hSubLast    = (r_hSub == SUB_W'(BLOCK_PX - 1));
  assign w_vSubLast    = (r_vSub == SUB_W'(BLOCK_PX - 1));

  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      r_hSub      <= '0;
      r_vSub      <= '0;
      r_gridCol   <= '0;
      r_gridRow   <= '0;
      r_gridRead  <= 1'b0;
      r_rgb       <= COLOUR_BLANK;
      r_hSync     <= 1'b1;
      r_vSync     <= 1'b1;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_tick && w_hLast && (w_vCount == CNT_W'(V_VIS - 1));
      if (w_tick) begin
        // Output stage shows the pixel the counters are leaving (one-pixel lag)
        r_rgb      <= w_visible ? blockColour(GridData) : COLOUR_BLANK;
        r_hSync    <= w_hSyncN;
        r_vSync    <= w_vSyncN;
        r_gridRead <= w_nextVisible;
        if (w_hLast) begin
          r_hSub    <= '0;
          r_gridCol <= '0;
          if (w_vLast) begin
            r_vSub    <= '0;
            r_gridRow <= '0;
          end else if (w_vSubLast) begin
            r_vSub    <= '0;
            r_gridRow <= r_gridRow + 1'b1;
          end else begin
            r_vSub <= r_vSub + 1'b1;
          end
        end else if (w_hSubLast) begin
          r_hSub    <= '0;
          r_gridCol <= r_gridCol + 1'b1;
        end else begin
          r_hSub <= r_hSub + 1'b1;
        end
      end
    end
  end

  assign GridRow   = r_gridRow;
  assign GridCol   = r_gridCol;
  assign GridRead  = r_gridRead;
  assign VGArgb    = r_rgb;
  assign VGAHSync  = r_hSync;
  assign VGAVSync  = r_vSync;
  assign FrameDone = r_frameDone;

endmodule

`default_nettype wire

// File: tb/tb_grid_vga_scanner.sv
// ============================================================================
// Module      : tb_grid_vga_scanner
// Description : Self-checking bench for grid_vga_scanner on a reduced raster.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_grid_vga_scanner;

  localparam int CLK_DIV = 2;
  localparam int BP      = 2;
  localparam int H_VIS = 128, H_FP = 2, H_SW = 4, H_BP = 2;
  localparam int V_VIS = 96,  V_FP = 2, V_SW = 2, V_BP = 2;
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] gridRow;
  logic [5:0] gridCol;
  logic       gridRead;
  logic [1:0] gridData = 2'd0;
  logic [7:0] rgb;
  logic       hs;
  logic       vs;
  logic       frameDone;

  always #5 clk = ~clk;

  grid_vga_scanner #(
    .CLK_DIV (CLK_DIV), .BLOCK_PX (BP),
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SW (H_SW), .H_BP (H_BP),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SW (V_SW), .V_BP (V_BP)
  ) dut (
    .MasterClock (clk),
    .Reset       (rst),
    .GridRow     (gridRow),
    .GridCol     (gridCol),
    .GridRead    (gridRead),
    .GridData    (gridData),
    .VGArgb      (rgb),
    .VGAHSync    (hs),
    .VGAVSync    (vs),
    .FrameDone   (frameDone)
  );

  function automatic logic [1:0] cellCode(input logic [5:0] r, input logic [5:0] c);
    if (r == 6'd0 && c == 6'd0)   return 2'd1;
    if (r == 6'd0 && c == 6'd1)   return 2'd2;
    if (r == 6'd47 && c == 6'd63) return 2'd3;
    if (r == 6'd10 && c == 6'd29) return 2'd3;
    return 2'd0;
  endfunction

  // synchronous-read grid RAM
  always @(posedge clk) gridData <= cellCode(gridRow, gridCol);

  function automatic logic [7:0] colourOf(input logic [1:0] code);
    case (code)
      2'd1:    return 8'hFF;
      2'd2:    return 8'h1C;
      2'd3:    return 8'hE0;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit vis(input int h, input int v);
    return (h < H_VIS) && (v < V_VIS);
  endfunction

  // {colour, hsync, vsync} expected once pixel (h,v) reaches the output stage
  function automatic logic [9:0] pixelOut(input int h, input int v);
    logic [7:0] c;
    logic       hsE;
    logic       vsE;
    c   = vis(h, v) ? colourOf(cellCode(6'(v / BP), 6'(h / BP))) : 8'h00;
    hsE = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SW);
    vsE = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SW);
    return {c, hsE, vsE};
  endfunction

  int         nChk = 0;
  int         nErr = 0;
  int         md, mh, mv;
  bit         ticked;
  logic [9:0] curOut;
  logic [9:0] sb[$];
  int         cyc = 0;
  int         pulses = 0;
  int         p1 = 0;
  int         p2 = 0;
  int         foodSeen = 0;

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nErr);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    if (nErr >= 40) summary();
  endtask

  task automatic resetModel();
    md     = 0;
    mh     = 0;
    mv     = 0;
    ticked = 1'b0;
    curOut = {8'h00, 1'b1, 1'b1};
    sb.delete();
    sb.push_back(pixelOut(0, 0));
  endtask

  // One MasterClock cycle: advance the model, then compare every output
  task automatic step();
    bit tickNow;
    bit fdExp;
    @(posedge clk);
    cyc++;
    tickNow = (md == CLK_DIV - 1);
    md      = tickNow ? 0 : md + 1;
    fdExp   = 1'b0;
    #1;
    if (tickNow) begin
      if (sb.size() == 0) chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      else curOut = sb.pop_front();
      fdExp = (mh == H_TOT - 1) && (mv == V_VIS - 1);
      if (mh == H_TOT - 1) begin
        mh = 0;
        mv = (mv == V_TOT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      ticked = 1'b1;
      sb.push_back(pixelOut(mh, mv));
      if (rgb === 8'hE0 && pulses == 0) foodSeen++;
    end
    chk("pixel_out", 32'({rgb, hs, vs}), 32'(curOut));
    chk("frame_done", 32'(frameDone), 32'(fdExp));
    chk("grid_read", 32'(gridRead), 32'(ticked && vis(mh, mv)));
    if (vis(mh, mv)) begin
      chk("grid_col", 32'(gridCol), 32'(mh / BP));
      chk("grid_row", 32'(gridRow), 32'(mv / BP));
    end
    if (frameDone === 1'b1) begin
      pulses++;
      if (pulses == 1) p1 = cyc;
      else if (pulses == 2) p2 = cyc;
    end
  endtask

  initial begin
    int pulsesBefore;

    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("reset_rgb", 32'(rgb), 32'h00);
    chk("reset_hsync", 32'(hs), 32'd1);
    chk("reset_vsync", 32'(vs), 32'd1);
    chk("reset_gridread", 32'(gridRead), 32'd0);
    chk("reset_addr", 32'({gridRow, gridCol}), 32'd0);
    chk("reset_framedone", 32'(frameDone), 32'd0);

    resetModel();
    rst = 1'b0;

    // Two full frames of free running with per-cycle scoreboard checks
    for (int i = 0; i < 70000 && pulses < 2; i++) step();
    chk("frame_pulses", 32'(pulses), 32'd2);
    chk("frame_period_cycles", 32'(p2 - p1), 32'(H_TOT * V_TOT * CLK_DIV));
    chk("food_pixels_frame1", 32'(foodSeen), 32'd8);

    // Run into the next frame up to pixel (60,20), then reset mid-frame
    for (int i = 0; i < 20000 && !(mh == 60 && mv == 20); i++) step();
    chk("pre_reset_rgb", 32'(rgb), 32'hE0);
    chk("pre_reset_col", 32'(gridCol), 32'd30);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rgb", 32'(rgb), 32'h00);
    chk("async_sync", 32'({hs, vs}), 32'b11);
    chk("async_gridread", 32'(gridRead), 32'd0);
    chk("async_addr", 32'({gridRow, gridCol}), 32'd0);
    chk("async_framedone", 32'(frameDone), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("held_reset_rgb", 32'(rgb), 32'h00);
    chk("held_reset_gridread", 32'(gridRead), 32'd0);

    resetModel();
    pulsesBefore = pulses;
    rst = 1'b0;
    for (int i = 0; i < 3 * H_TOT * CLK_DIV; i++) step();
    chk("no_partial_pulse", 32'(pulses), 32'(pulsesBefore));

    summary();
  end

endmodule

`default_nettype wire
